// File: rtl/nco_pkg.sv
// Shared definitions for the NCO configuration controller.
// Holds the UI state codes, waveform codes, control FSM states and default sizes.
package nco_pkg;

  localparam int unsigned NCO_ACC_W    = 32;
  localparam int unsigned NCO_FREQ_W   = 16;
  localparam int unsigned NCO_PINC_K   = 4295;   // round(2^32 / 1 MHz)
  localparam int unsigned NCO_FREQ_MAX = 20000;  // clamp ceiling in Hz

  // UI state codes driven by the upstream control state machine
  typedef enum logic [2:0] {
    S0 = 3'd0,  // reset
    S1 = 3'd1,  // select signal
    S2 = 3'd2,  // display signal
    S3 = 3'd3,  // select frequency
    S4 = 3'd4,  // display frequency
    S5 = 3'd5   // run
  } ui_state_e;

  typedef enum logic [1:0] {
    WAVE_SINE     = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SAW      = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_MUL  = 2'd1,
    CTRL_DONE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/nco_shift_add_mult.sv
// Serial shift-add multiplier: product = mcand * PINC_K, one multiplicand bit per cycle.
// Ports:
//   clk, rst (sync active-low)
//   start   : load mcand and begin (also restarts a running multiply)
//   abort   : stop immediately, no done pulse
//   mcand   : FREQ_W-bit multiplicand
//   busy    : multiply in progress (registered)
//   done    : one-cycle pulse after the last step (registered)
//   product : ACC_W-bit result, valid while done is high
module nco_shift_add_mult
  import nco_pkg::*;
#(
  parameter int unsigned FREQ_W = NCO_FREQ_W,
  parameter int unsigned ACC_W  = NCO_ACC_W,
  parameter int unsigned PINC_K = NCO_PINC_K
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [FREQ_W-1:0] mcand,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  product
);

  localparam int unsigned PP_W  = FREQ_W + 14;
  localparam int unsigned CNT_W = $clog2(FREQ_W) + 1;

  logic [FREQ_W-1:0] mcand_q, mcand_d;
  logic [PP_W-1:0]   addend_q, addend_d;
  logic [PP_W-1:0]   pp_q, pp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // LSB-first: add the shifted constant when the current multiplicand bit is set
  always_comb begin
    mcand_d  = mcand_q;
    addend_d = addend_q;
    pp_d     = pp_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = mcand;
      addend_d = PP_W'(PINC_K);
      pp_d     = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (abort) begin
      busy_d = 1'b0;
    end else if (busy_q) begin
      if (mcand_q[0]) pp_d = pp_q + addend_q;
      addend_d = addend_q << 1;
      mcand_d  = mcand_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(FREQ_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand_q  <= '0;
      addend_q <= '0;
      pp_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      addend_q <= addend_d;
      pp_q     <= pp_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = ACC_W'(pp_q);

endmodule

// File: rtl/nco_config_ctrl.sv
// NCO configuration controller: follows the UI state code, captures waveform and
// frequency settings on state entries, computes the phase increment serially and
// gates the NCO run enable.
// Optional feature macro: NCO_CFG_CLAMP_EN (clamp captured frequency to NCO_FREQ_MAX).
// Ports:
//   clk_1MHz, rst (sync active-low)
//   state_in  : UI state code 0..5 (6/7 illegal)
//   wave_sw   : waveform switches      freq_sw : frequency switches (Hz)
//   wave_sel  : latched waveform       freq_hz : latched frequency
//   phase_inc : freq_hz * PINC_K       inc_valid : phase_inc matches freq_hz
//   nco_run   : accumulator enable     busy : multiplier running
//   code_err  : sticky illegal code    clamped : last capture was clamped
module nco_config_ctrl
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W  = NCO_ACC_W,
  parameter int unsigned FREQ_W = NCO_FREQ_W,
  parameter int unsigned PINC_K = NCO_PINC_K
) (
  input  logic              clk_1MHz,
  input  logic              rst,
  input  logic [2:0]        state_in,
  input  logic [1:0]        wave_sw,
  input  logic [FREQ_W-1:0] freq_sw,
  output logic [1:0]        wave_sel,
  output logic [FREQ_W-1:0] freq_hz,
  output logic [ACC_W-1:0]  phase_inc,
  output logic              inc_valid,
  output logic              nco_run,
  output logic              busy,
  output logic              code_err,
  output logic              clamped
);

  logic [2:0]        state_prev_q, state_prev_d;
  logic [1:0]        wave_sel_q, wave_sel_d;
  logic [FREQ_W-1:0] freq_hz_q, freq_hz_d;
  logic [ACC_W-1:0]  phase_inc_q, phase_inc_d;
  logic              inc_valid_q, inc_valid_d;
  logic              nco_run_q, nco_run_d;
  logic              code_err_q, code_err_d;
  logic              clamped_q, clamped_d;
  ctrl_state_e       fsm_q, fsm_d;

  logic              entry_c, illegal_c, restart_c, cap_wave_c, cap_freq_c;
  logic              clamp_hit_c;
  logic [FREQ_W-1:0] freq_cap_c;
  logic              mul_busy, mul_done;
  logic [ACC_W-1:0]  mul_product;

  // Entry decode; illegal codes behave as an entry to the reset state
  always_comb begin
    entry_c    = (state_in != state_prev_q);
    illegal_c  = (state_in > 3'd5);
    restart_c  = entry_c && ((state_in == S0) || (state_in == S1) || illegal_c);
    cap_wave_c = entry_c && (state_in == S2);
    cap_freq_c = entry_c && (state_in == S4);
  end

`ifdef NCO_CFG_CLAMP_EN
  always_comb begin
    clamp_hit_c = (freq_sw > FREQ_W'(NCO_FREQ_MAX));
    freq_cap_c  = clamp_hit_c ? FREQ_W'(NCO_FREQ_MAX) : freq_sw;
  end
`else
  always_comb begin
    clamp_hit_c = 1'b0;
    freq_cap_c  = freq_sw;
  end
`endif

  nco_shift_add_mult #(
    .FREQ_W (FREQ_W),
    .ACC_W  (ACC_W),
    .PINC_K (PINC_K)
  ) u_mult (
    .clk     (clk_1MHz),
    .rst     (rst),
    .start   (cap_freq_c),
    .abort   (restart_c),
    .mcand   (freq_cap_c),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM and capture registers; restart beats capture beats completion
  always_comb begin
    state_prev_d = state_in;
    wave_sel_d   = wave_sel_q;
    freq_hz_d    = freq_hz_q;
    phase_inc_d  = phase_inc_q;
    inc_valid_d  = inc_valid_q;
    code_err_d   = code_err_q | illegal_c;
    clamped_d    = clamped_q;
    fsm_d        = fsm_q;

    if (cap_wave_c) wave_sel_d = wave_sw;

    if (restart_c) begin
      fsm_d       = CTRL_IDLE;
      inc_valid_d = 1'b0;
    end else if (cap_freq_c) begin
      freq_hz_d   = freq_cap_c;
      clamped_d   = clamp_hit_c;
      inc_valid_d = 1'b0;
      fsm_d       = CTRL_MUL;
    end else if ((fsm_q == CTRL_MUL) && mul_done) begin
      phase_inc_d = mul_product;
      inc_valid_d = 1'b1;
      fsm_d       = CTRL_DONE;
    end

    nco_run_d = (state_in == S5) && inc_valid_q && (freq_hz_q != '0);
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst) begin
      state_prev_q <= '0;
      wave_sel_q   <= '0;
      freq_hz_q    <= '0;
      phase_inc_q  <= '0;
      inc_valid_q  <= 1'b0;
      nco_run_q    <= 1'b0;
      code_err_q   <= 1'b0;
      clamped_q    <= 1'b0;
      fsm_q        <= CTRL_IDLE;
    end else begin
      state_prev_q <= state_prev_d;
      wave_sel_q   <= wave_sel_d;
      freq_hz_q    <= freq_hz_d;
      phase_inc_q  <= phase_inc_d;
      inc_valid_q  <= inc_valid_d;
      nco_run_q    <= nco_run_d;
      code_err_q   <= code_err_d;
      clamped_q    <= clamped_d;
      fsm_q        <= fsm_d;
    end
  end

  assign wave_sel  = wave_sel_q;
  assign freq_hz   = freq_hz_q;
  assign phase_inc = phase_inc_q;
  assign inc_valid = inc_valid_q;
  assign nco_run   = nco_run_q;
  assign busy      = mul_busy;
  assign code_err  = code_err_q;
  assign clamped   = clamped_q;

endmodule
